// File: rtl/srlatch_pkg.sv
// Shared types and helpers for the clocked set/reset latch bank.
package srlatch_pkg;

   localparam int unsigned REQ_W = 2;

   typedef enum logic [1:0] {
      RST  = 2'b00,
      SET  = 2'b01,
      BOTH = 2'b10
   } srl_state_t;

   typedef enum logic [1:0] {
      NOR    = 2'b00,
      SETDOM = 2'b01,
      RSTDOM = 2'b10,
      HOLD   = 2'b11
   } srl_mode_t;

   // Output pair carried through the latency pipeline
   typedef struct packed {
      logic q;
      logic nq;
   } srl_qnq_t;

   localparam logic [REQ_W-1:0] REQ_NONE = 2'b00;
   localparam logic [REQ_W-1:0] REQ_RST  = 2'b01;
   localparam logic [REQ_W-1:0] REQ_SET  = 2'b10;
   localparam logic [REQ_W-1:0] REQ_BOTH = 2'b11;

   localparam srl_qnq_t RST_QNQ = '{q: 1'b0, nq: 1'b1};

   // Map a latch state onto its visible {q,nq} pair
   function automatic srl_qnq_t state_to_qnq(input srl_state_t st);
      srl_qnq_t o;
      case (st)
         SET:     o = '{q: 1'b1, nq: 1'b0};
         BOTH:    o = '{q: 1'b0, nq: 1'b0};
         default: o = RST_QNQ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/srlatch_chan.sv
// One latch channel: persistence filter, three-state latch and sticky conflict flag.
module srlatch_chan
   import srlatch_pkg::*;
#(
   parameter int unsigned FILT = 0
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       i_s,
   input  logic       i_r,
   input  logic [1:0] i_mode,
   input  logic       i_clr_conflict,
   output logic       o_q_nxt_c,
   output logic       o_nq_nxt_c,
   output logic       o_conflict
);

   localparam int unsigned      CNT_W   = (FILT > 0) ? $clog2(FILT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT);

   srl_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [REQ_W-1:0] r_prev;
   logic             r_conflict;

   srl_state_t       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_conflict_nxt;
   logic             w_qual;
   logic [REQ_W-1:0] w_req;
   srl_mode_t        w_mode;
   srl_qnq_t         w_qnq_nxt;

   assign w_req  = {i_s, i_r};
   assign w_mode = srl_mode_t'(i_mode);

   // Filter count, qualification and next latch state / conflict flag
   always_comb begin
      w_cnt_nxt      = '0;
      w_qual         = 1'b0;
      w_state_nxt    = r_state;
      w_conflict_nxt = r_conflict;

      if ((w_req != REQ_NONE) && (w_req == r_prev)) begin
         w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
      end
      w_qual = (w_req != REQ_NONE) && (w_cnt_nxt == CNT_MAX);

      if (i_clr_conflict) begin
         w_conflict_nxt = 1'b0;
      end

      if (w_mode != HOLD) begin
         if ((r_state == BOTH) && (w_req != REQ_BOTH)) begin
            // Releasing both inputs falls back to RST unless a set qualifies now
            w_state_nxt = (w_qual && (w_req == REQ_SET)) ? SET : RST;
         end else if (w_qual) begin
            case (w_req)
               REQ_SET: w_state_nxt = SET;
               REQ_RST: w_state_nxt = RST;
               REQ_BOTH: begin
                  w_conflict_nxt = 1'b1;
                  case (w_mode)
                     NOR:     w_state_nxt = BOTH;
                     SETDOM:  w_state_nxt = SET;
                     RSTDOM:  w_state_nxt = RST;
                     default: w_state_nxt = r_state;
                  endcase
               end
               default: w_state_nxt = r_state;
            endcase
         end
      end
   end

   // Channel state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state    <= RST;
         r_cnt      <= '0;
         r_prev     <= REQ_NONE;
         r_conflict <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_prev     <= w_req;
         r_conflict <= w_conflict_nxt;
      end
   end

   assign w_qnq_nxt  = state_to_qnq(w_state_nxt);
   assign o_q_nxt_c  = w_qnq_nxt.q;
   assign o_nq_nxt_c = w_qnq_nxt.nq;
   assign o_conflict = r_conflict;

endmodule

// File: rtl/srlatch_bank.sv
// Bank of independent clocked set/reset latches with a fixed-latency output pipeline.
module srlatch_bank
   import srlatch_pkg::*;
#(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned FILT     = 0,
   parameter int unsigned LAT      = 1
) (
   input  logic                    clk,
   input  logic                    nreset,
   input  logic [CHANNELS-1:0]     s,
   input  logic [CHANNELS-1:0]     r,
   input  logic [2*CHANNELS-1:0]   mode,
   input  logic [CHANNELS-1:0]     clr_conflict,
   output logic [CHANNELS-1:0]     q,
   output logic [CHANNELS-1:0]     nq,
   output logic [CHANNELS-1:0]     conflict
);

   srl_qnq_t [CHANNELS-1:0]          w_stage0;
   srl_qnq_t [LAT-1:0][CHANNELS-1:0] r_pipe;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      srlatch_chan #(
         .FILT (FILT)
      ) u_chan (
         .clk            (clk),
         .nreset         (nreset),
         .i_s            (s[gi]),
         .i_r            (r[gi]),
         .i_mode         (mode[2*gi+1 -: 2]),
         .i_clr_conflict (clr_conflict[gi]),
         .o_q_nxt_c      (w_stage0[gi].q),
         .o_nq_nxt_c     (w_stage0[gi].nq),
         .o_conflict     (conflict[gi])
      );

      assign q[gi]  = r_pipe[LAT-1][gi].q;
      assign nq[gi] = r_pipe[LAT-1][gi].nq;
   end

   if (LAT > 1) begin : g_deep
      // Shift the applied state through LAT stages; reset fills every stage with RST
      always_ff @(posedge clk) begin
         if (!nreset) begin
            r_pipe <= {(LAT*CHANNELS){RST_QNQ}};
         end else begin
            r_pipe <= {r_pipe[LAT-2:0], w_stage0};
         end
      end
   end else begin : g_flat
      // Single stage: outputs follow the state applied on this edge
      always_ff @(posedge clk) begin
         if (!nreset) begin
            r_pipe <= {(LAT*CHANNELS){RST_QNQ}};
         end else begin
            r_pipe <= w_stage0;
         end
      end
   end

endmodule

// File: tb/tb_srlatch_bank.sv
// Scoreboard bench for srlatch_bank across four parameter sets.
`timescale 1ns/1ps
module tb_srlatch_bank;

   localparam int ND = 4;   // 0: F0/L1  1: F2/L1  2: F0/L3  3: F3/L1

   typedef struct {
      int         dut;
      int         due;
      logic [3:0] q;
      logic [3:0] nq;
      logic [3:0] cf;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       nreset_v [ND];
   logic [3:0] s_v   [ND];
   logic [3:0] r_v   [ND];
   logic [3:0] clr_v [ND];
   logic [7:0] mode_v[ND];
   logic [3:0] q_v   [ND];
   logic [3:0] nq_v  [ND];
   logic [3:0] cf_v  [ND];

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   srlatch_bank #(.CHANNELS(4), .FILT(0), .LAT(1)) u_dut0 (
      .clk(clk), .nreset(nreset_v[0]), .s(s_v[0]), .r(r_v[0]), .mode(mode_v[0]),
      .clr_conflict(clr_v[0]), .q(q_v[0]), .nq(nq_v[0]), .conflict(cf_v[0]));
   srlatch_bank #(.CHANNELS(4), .FILT(2), .LAT(1)) u_dut1 (
      .clk(clk), .nreset(nreset_v[1]), .s(s_v[1]), .r(r_v[1]), .mode(mode_v[1]),
      .clr_conflict(clr_v[1]), .q(q_v[1]), .nq(nq_v[1]), .conflict(cf_v[1]));
   srlatch_bank #(.CHANNELS(4), .FILT(0), .LAT(3)) u_dut2 (
      .clk(clk), .nreset(nreset_v[2]), .s(s_v[2]), .r(r_v[2]), .mode(mode_v[2]),
      .clr_conflict(clr_v[2]), .q(q_v[2]), .nq(nq_v[2]), .conflict(cf_v[2]));
   srlatch_bank #(.CHANNELS(4), .FILT(3), .LAT(1)) u_dut3 (
      .clk(clk), .nreset(nreset_v[3]), .s(s_v[3]), .r(r_v[3]), .mode(mode_v[3]),
      .clr_conflict(clr_v[3]), .q(q_v[3]), .nq(nq_v[3]), .conflict(cf_v[3]));

   // Pop every expectation that falls due on this cycle and compare it
   always @(negedge clk) begin
      int   i;
      exp_t e;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].due <= cyc) begin
            e = sb[i];
            sb.delete(i);
            n_chk++;
            if ({q_v[e.dut], nq_v[e.dut], cf_v[e.dut]} !== {e.q, e.nq, e.cf}) begin
               $display("FAIL %s (dut%0d cyc %0d): got q=%b nq=%b cf=%b, want q=%b nq=%b cf=%b",
                        e.name, e.dut, cyc, q_v[e.dut], nq_v[e.dut], cf_v[e.dut], e.q, e.nq, e.cf);
            end else begin
               n_pass++;
            end
         end else begin
            i++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Queue an expectation k edges from now
   task automatic push(input int d, input int k, input logic [3:0] eq, input logic [3:0] enq,
                       input logic [3:0] ecf, input string nm);
      exp_t e;
      e.dut = d; e.due = cyc + k; e.q = eq; e.nq = enq; e.cf = ecf; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      for (int d = 0; d < ND; d++) begin
         nreset_v[d] = 1'b0;
         push(d, 2, 4'h0, 4'hF, 4'h0, "reset");
      end
      tick();
      tick();
      n_chk++;
      if (nq_v[2] !== 4'hF) $display("FAIL reset_lat3_nq: got %b want 1111", nq_v[2]);
      else n_pass++;
      for (int d = 0; d < ND; d++) nreset_v[d] = 1'b1;
   endtask

   task automatic test_basic();
      s_v[0] = 4'b0001;
      push(0, 1, 4'b0001, 4'b1110, 4'h0, "basic_set");
      tick();
      s_v[0] = 4'b0000;
      push(0, 1, 4'b0001, 4'b1110, 4'h0, "basic_hold");
      tick();
      r_v[0] = 4'b0001;
      push(0, 1, 4'b0000, 4'b1111, 4'h0, "basic_reset");
      tick();
      r_v[0] = 4'b0000;
      n_chk++;
      if (q_v[0] !== 4'h0) $display("FAIL basic_final_q: got %b want 0000", q_v[0]);
      else n_pass++;
   endtask

   task automatic test_conflict_modes();
      mode_v[0] = 8'b11_10_01_00;
      s_v[0] = 4'hF; r_v[0] = 4'hF;
      push(0, 1, 4'b0010, 4'b1100, 4'b0111, "both_per_mode");
      tick();
      s_v[0] = 4'h0; r_v[0] = 4'h0;
      push(0, 1, 4'b0010, 4'b1101, 4'b0111, "both_release");
      tick();
      n_chk++;
      if (cf_v[0] !== 4'b0111) $display("FAIL conflict_hold_mode: got %b want 0111", cf_v[0]);
      else n_pass++;
   endtask

   task automatic test_sticky();
      clr_v[0] = 4'b0001; s_v[0] = 4'b0001; r_v[0] = 4'b0001;
      push(0, 1, 4'b0010, 4'b1100, 4'b0111, "sticky_set_wins");
      tick();
      s_v[0] = 4'b0000; r_v[0] = 4'b0000;
      push(0, 1, 4'b0010, 4'b1101, 4'b0110, "sticky_clear");
      tick();
      clr_v[0] = 4'b1110;
      push(0, 1, 4'b0010, 4'b1101, 4'b0000, "sticky_clear_rest");
      tick();
      clr_v[0] = 4'b0000; mode_v[0] = 8'h00;
      s_v[0] = 4'b0001; r_v[0] = 4'b0001;
      push(0, 1, 4'b0010, 4'b1100, 4'b0001, "both_enter");
      tick();
      r_v[0] = 4'b0000;
      push(0, 1, 4'b0011, 4'b1100, 4'b0001, "both_exit_to_set");
      tick();
      s_v[0] = 4'b0000; r_v[0] = 4'hF;
      push(0, 1, 4'b0000, 4'b1111, 4'b0001, "all_reset");
      tick();
      r_v[0] = 4'b0000;
      n_chk++;
      if (cf_v[0] !== 4'b0001) $display("FAIL sticky_final_cf: got %b want 0001", cf_v[0]);
      else n_pass++;
   endtask

   task automatic test_filter();
      logic [3:0] seq_s [5];
      logic [3:0] seq_r [5];
      seq_s = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
      seq_r = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
      for (int k = 0; k < 3; k++) begin
         s_v[1] = (k < 2) ? 4'b0001 : 4'b0000;
         push(1, 1, 4'h0, 4'hF, 4'h0, "filt_short_pulse");
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         s_v[1] = 4'b0001;
         if (k < 2) push(1, 1, 4'h0, 4'hF, 4'h0, "filt_pending");
         else       push(1, 1, 4'b0001, 4'b1110, 4'h0, "filt_qualified");
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         s_v[1] = seq_s[k]; r_v[1] = seq_r[k];
         if (k < 4) push(1, 1, 4'b0001, 4'b1110, 4'h0, "filt_restart");
         else       push(1, 1, 4'b0001, 4'b1100, 4'b0010, "filt_both_edge5");
         tick();
      end
      s_v[1] = 4'h0; r_v[1] = 4'h0;
      push(1, 1, 4'b0001, 4'b1110, 4'b0010, "filt_both_release");
      tick();
      n_chk++;
      if (q_v[1] !== 4'b0001) $display("FAIL filt_final_q: got %b want 0001", q_v[1]);
      else n_pass++;
   endtask

   task automatic test_latency();
      s_v[2] = 4'b0011; r_v[2] = 4'b0010;
      push(2, 1, 4'h0,    4'hF,    4'b0010, "lat_edge0");
      push(2, 2, 4'h0,    4'hF,    4'b0010, "lat_edge1");
      push(2, 3, 4'b0001, 4'b1100, 4'b0010, "lat_edge2");
      push(2, 4, 4'b0001, 4'b1110, 4'b0010, "lat_edge3");
      tick();
      s_v[2] = 4'h0; r_v[2] = 4'h0;
      tick();
      tick();
      tick();
      n_chk++;
      if (q_v[2] !== 4'b0001) $display("FAIL lat_final_q: got %b want 0001", q_v[2]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      s_v[3] = 4'b0001;
      push(3, 1, 4'h0, 4'hF, 4'h0, "mid_pre1");
      tick();
      push(3, 1, 4'h0, 4'hF, 4'h0, "mid_pre2");
      tick();
      nreset_v[3] = 1'b0;
      push(3, 1, 4'h0, 4'hF, 4'h0, "mid_reset");
      tick();
      nreset_v[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k < 3) push(3, 1, 4'h0, 4'hF, 4'h0, "mid_refill");
         else       push(3, 1, 4'b0001, 4'b1110, 4'h0, "mid_qualified");
         tick();
      end
      s_v[3] = 4'h0;
      n_chk++;
      if (nq_v[3] !== 4'b1110) $display("FAIL mid_final_nq: got %b want 1110", nq_v[3]);
      else n_pass++;
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         nreset_v[d] = 1'b0;
         s_v[d]      = 4'h0;
         r_v[d]      = 4'h0;
         clr_v[d]    = 4'h0;
         mode_v[d]   = 8'h00;
      end
      @(negedge clk);
      test_reset();
      test_basic();
      test_conflict_modes();
      test_sticky();
      test_filter();
      test_latency();
      test_reset_mid();
      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      n_chk++;
      if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/srlatch_bank.md
# srlatch_bank

Parametrised, clocked bank of set/reset latches for the DMG CPU model. It replaces free-running NOR latches where a deterministic reset state is needed, along with configurable set/reset priority, input glitch filtering and a fixed output latency. Each channel samples its own `s`/`r` pair on `clk`, qualifies it through a persistence filter, updates a three-state latch and drives `q`/`nq` through a short delay pipeline. Intended for cycle-accurate cells that must not power up random.

## Interface
- `CHANNELS`, default 8: number of independent latches (≥1).
- `FILT`, default 0: extra consecutive samples a request must persist before it is applied (0 means it applies immediately).
- `LAT`, default 1: clock edges from the applying edge to the visible output (≥1; LAT−1 extra pipeline stages).
- `clk`  in  1: sole clock, rising edge.
- `nreset`  in  1: reset, synchronous, active-low.
- `s`  in  CHANNELS: per-channel set request.
- `r`  in  CHANNELS: per-channel reset request.
- `mode`  in  2·CHANNELS: per-channel mode, bits [2i+1:2i]. Encoding: 00 NOR, 01 SETDOM, 10 RSTDOM, 11 HOLD.
- `clr_conflict`  in  CHANNELS: per-channel clear of the sticky conflict flag.
- `q`  out  CHANNELS: latch output.
- `nq`  out  CHANNELS: complementary output. It is not forced to equal ~q (see the BOTH state).
- `conflict`  out  CHANNELS: sticky flag; the channel accepted a simultaneous s and r request.

## Operation
- **Channel states**
  - RST: q=0, nq=1.
  - SET: q=1, nq=0.
  - BOTH: q=0, nq=0.
- **Raw request:** req={s[i],r[i]}, sampled every edge.
- **Filter:** per-channel counter cnt, saturating at FILT, width $clog2(FILT+1) (minimum 1). prev holds the previous raw req.
  - req≠prev or req=00: cnt←0.
  - Otherwise: cnt←min(cnt+1,FILT).
  - A request is *qualified* on an edge when req≠00 and it has been sampled on FILT+1 consecutive edges including the current one.
- **Transitions on a qualified request:**
  - 10 → SET.
  - 01 → RST.
  - 11, by mode:
    - NOR → BOTH.
    - SETDOM → SET.
    - RSTDOM → RST.
    - In all three modes, conflict←1.
  - HOLD mode ignores every request. State is held and conflict is unaffected.
- **Exit from BOTH:**
  - The first edge whose raw req≠11 moves to RST.
  - Exception: that same edge qualifies 10, which is only possible when FILT=0; the channel then moves to SET.
  - A mode change while in BOTH does not exit BOTH by itself.
- **Mode:** sampled on the same edge as req; a new mode applies from that edge.
- **Conflict flag:**
  - clr_conflict[i] clears it on the edge.
  - If a set and a clear occur on the same edge, the set wins.
- **Channel independence:** channels share only clk/nreset; there is no cross-channel interaction.
- **Reset (nreset=0 at an edge), for all channels:**
  - state=RST, cnt=0, prev=00, conflict=0.
  - Every pipeline stage is filled with RST values.
  - After reset: q=0, nq=all-ones, conflict=0.
  - Reset mid-filter discards the partial count. Reset dominates all other inputs.

## Timing
- Request first sampled at edge E:
  - It qualifies at edge E+FILT.
  - q/nq change after edge E+FILT+LAT−1.
  - With FILT=0, LAT=1, outputs change on the same edge that samples the request.
- conflict updates on the qualifying edge. It is not delayed by LAT.
- A request shorter than FILT+1 samples has no effect.
- A request changing value (10→11) restarts qualification.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `srlatch_pkg`:
  - enum `srl_state_t` {RST, SET, BOTH}.
  - enum `srl_mode_t` {NOR=2'b00, SETDOM, RSTDOM, HOLD}.
  - Function mapping state to {q,nq}.
- Sub-module `srlatch_chan`: one channel, holding the filter counter, prev, state and conflict.
  - `srlatch_bank` generates CHANNELS instances.
  - `srlatch_bank` owns the LAT-deep output pipeline, held as a packed array of {q,nq} per stage.

## Test plan
- **Reset and basic set/reset** (CHANNELS=4, FILT=0, LAT=1):
  - Hold nreset=0 for 2 edges → q=4'h0, nq=4'hF, conflict=0.
  - s=4'b0001 for one edge → q=4'b0001 after that edge.
  - r=4'b0001 → q=0, nq=4'hF.
- **Simultaneous s=r=1 per mode**, channels 0..3 in modes NOR/SETDOM/RSTDOM/HOLD, from RST:
  - Result q=4'b0010, nq=4'b1100, conflict=4'b0111.
  - Next edge with req=00 → channel 0 q=0, nq=1.
- **Filter** (FILT=2):
  - s pulse of 2 edges → q unchanged.
  - s held 3 edges → q=1 after the third edge.
  - Sequence 10,10,11,11,11 → qualifies 11 at edge 5 only.
- **Latency** (LAT=3, FILT=0):
  - s applied at edge 10 → q rises after edge 12.
  - conflict from an edge-10 s=r=1 sets after edge 10.
- **Sticky conflict:**
  - clr_conflict coincident with a qualified 11 → conflict stays 1.
  - clr_conflict alone next edge → 0.
- **Reset mid-operation** (FILT=3):
  - s held 2 edges, nreset=0 for 1 edge, s held 3 more edges → q still 0.
  - One further edge → q=1.
